// File: rtl/shift_counter_pkg.sv
// Shared constants and helpers for the parametrised shift-register counter.
package shift_counter_pkg;

    localparam logic [1:0] MODE_JOHNSON = 2'b00;
    localparam logic [1:0] MODE_RING    = 2'b01;
    localparam logic [1:0] MODE_HOLD    = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int HOME_MAX_W = 64;

    // Home state: ring restarts at bit 0 set, every other mode homes at zero.
    // Callers truncate the result to their own width.
    function automatic logic [HOME_MAX_W-1:0] home_state(input logic [1:0] mode);
        return (mode == MODE_RING) ? HOME_MAX_W'(1) : '0;
    endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational position decode and legality check of the counter state.
module shift_counter_decode
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0]             q,
    input  logic [1:0]                   mode,
    output logic [$clog2(2*WIDTH)-1:0]   index,
    output logic                         illegal
);

    localparam int IDX_W = $clog2(2*WIDTH);

    logic [IDX_W-1:0] pop;
    logic [IDX_W-1:0] flips;
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] j_idx;
    logic             ring;

    always_comb begin
        pop   = '0;
        flips = '0;
        pos   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + IDX_W'(q[i]);
            if (q[i]) pos = IDX_W'(i);
        end
        for (int i = 0; i < WIDTH-1; i++)
            flips = flips + IDX_W'(q[i] ^ q[i+1]);
    end

    // Modular arithmetic keeps 2*WIDTH - pop correct even when 2*WIDTH == 2**IDX_W.
    assign j_idx   = q[WIDTH-1] ? (IDX_W'(2*WIDTH) - pop) : pop;
    assign ring    = (mode == MODE_RING);
    assign illegal = ring ? (pop != IDX_W'(1)) : (flips > IDX_W'(1));
    assign index   = illegal ? '0 : (ring ? pos : j_idx);

endmodule

// File: rtl/shift_counter.sv
// Johnson / ring / hold shift counter with load, direction, wrap and err.
// Build option: SHIFT_COUNTER_SELF_CORRECT_EN forces illegal states home on a step.
module shift_counter
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         dir,
    input  logic                         load,
    input  logic [WIDTH-1:0]             load_val,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(2*WIDTH)-1:0]   index,
    output logic                         wrap,
    output logic                         err
);

    localparam int IDX_W = $clog2(2*WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] home;
    logic             wrap_nxt;
    logic             illegal;
    logic             stepping;
    logic             ring;
    logic             fill;

    shift_counter_decode #(.WIDTH(WIDTH)) u_decode (
        .q       (q),
        .mode    (mode),
        .index   (index),
        .illegal (illegal)
    );

    assign err      = illegal;
    assign home     = WIDTH'(home_state(mode));
    assign ring     = (mode == MODE_RING);
    assign stepping = en && (mode == MODE_JOHNSON || ring);
    // Bit shifted in: ring recirculates, Johnson inverts.
    assign fill     = (dir == DIR_DOWN) ? (ring ? q[0] : ~q[0])
                                        : (ring ? q[WIDTH-1] : ~q[WIDTH-1]);

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = load_val;
        end else if (stepping) begin
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
            if (illegal) begin
`else
            if (ring && q == '0) begin
`endif
                q_nxt    = home;
                wrap_nxt = 1'b1;
            end else begin
                q_nxt    = (dir == DIR_DOWN) ? {fill, q[WIDTH-1:1]}
                                             : {q[WIDTH-2:0], fill};
                wrap_nxt = (q_nxt == home);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_shift_counter.sv
// Directed bench for shift_counter at WIDTH 5 and 8.
module tb_shift_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [4:0] load_val = '0;
    logic [4:0] q;
    logic [3:0] index;
    logic       wrap, err;

    logic       en8 = 1'b0, dir8 = 1'b0, load8 = 1'b0;
    logic [1:0] mode8 = 2'b00;
    logic [7:0] load_val8 = '0;
    logic [7:0] q8;
    logic [3:0] index8;
    logic       wrap8, err8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_counter #(.WIDTH(5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .q(q), .index(index), .wrap(wrap), .err(err)
    );

    shift_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .mode(mode8), .dir(dir8), .load(load8),
        .load_val(load_val8), .q(q8), .index(index8), .wrap(wrap8), .err(err8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] j_seq [10] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                               5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
    logic [4:0] r_seq [6]  = '{5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    logic [3:0] r_idx [6]  = '{4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic [7:0] w8_seq [7] = '{8'h01, 8'h03, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};
    logic [3:0] w8_idx [7] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15};

    initial begin
        // 1: reset, then Johnson up
        tick(); tick();
        chk("rst_q", 32'(q), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_idx", 32'(index), 0);
        rst = 1'b1; mode = 2'b00; dir = 1'b0; en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("j_up_q%0d", k), 32'(q), 32'(j_seq[k]));
            chk($sformatf("j_up_idx%0d", k), 32'(index), (k == 9) ? 0 : k + 1);
            chk($sformatf("j_up_wrap%0d", k), 32'(wrap), (k == 9) ? 1 : 0);
        end

        // 2: ring down from reset, seed first
        #2 rst = 1'b0; mode = 2'b01; dir = 1'b1;
        #1 chk("ring_zero_err", 32'(err), 1);
        chk("ring_zero_q", 32'(q), 0);
        @(negedge clk) rst = 1'b1;
        #1 chk("ring_zero_err_rel", 32'(err), 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("r_dn_q%0d", k), 32'(q), 32'(r_seq[k]));
            chk($sformatf("r_dn_idx%0d", k), 32'(index), 32'(r_idx[k]));
            chk($sformatf("r_dn_wrap%0d", k), 32'(wrap), (k == 0 || k == 5) ? 1 : 0);
            chk($sformatf("r_dn_err%0d", k), 32'(err), 0);
        end

        // 3: load an illegal Johnson state
        mode = 2'b00; dir = 1'b0; en = 1'b0; load = 1'b1; load_val = 5'b01010;
        tick();
        chk("ld_q", 32'(q), 32'h0a);
        chk("ld_err", 32'(err), 1);
        chk("ld_idx", 32'(index), 0);
        chk("ld_wrap", 32'(wrap), 0);
        load = 1'b0; en = 1'b1;
        tick();
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
        chk("fix_q", 32'(q), 0);
        chk("fix_wrap", 32'(wrap), 1);
        chk("fix_err", 32'(err), 0);
`else
        chk("ill_q", 32'(q), 32'h15);
        chk("ill_wrap", 32'(wrap), 0);
        chk("ill_err", 32'(err), 1);
`endif

        // 4: load beats en; hold ignores en and dir; en low holds
        load = 1'b1; load_val = 5'b00111;
        tick();
        chk("pri_q", 32'(q), 32'h07);
        chk("pri_wrap", 32'(wrap), 0);
        load = 1'b0; mode = 2'b10; dir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_q%0d", k), 32'(q), 32'h07);
            chk($sformatf("hold_wrap%0d", k), 32'(wrap), 0);
            chk($sformatf("hold_idx%0d", k), 32'(index), 3);
        end
        mode = 2'b00; dir = 1'b0; en = 1'b0;
        tick();
        chk("en0_q", 32'(q), 32'h07);

        // 5: async reset between edges
        load = 1'b1; load_val = 5'b01111;
        tick();
        chk("pre_rst_q", 32'(q), 32'h0f);
        load = 1'b0;
        #2 rst = 1'b0;
        #1 chk("async_q", 32'(q), 0);
        chk("async_wrap", 32'(wrap), 0);
        @(negedge clk) rst = 1'b1; en = 1'b1;
        tick();
        chk("resume_q", 32'(q), 32'h01);
        chk("resume_idx", 32'(index), 1);
        en = 1'b0;

        // 6: WIDTH 8 Johnson, reverse after 00000111
        mode8 = 2'b00; dir8 = 1'b0; en8 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("w8_q%0d", k), 32'(q8), 32'(w8_seq[k]));
            chk($sformatf("w8_idx%0d", k), 32'(index8), 32'(w8_idx[k]));
            chk($sformatf("w8_wrap%0d", k), 32'(wrap8), (k == 5) ? 1 : 0);
            if (k == 2) dir8 = 1'b1;
        end
        chk("w8_err", 32'(err8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_counter.md
Name: shift_counter

Overview:
Parametrised shift-register counter. Generalises the fixed 5-bit Johnson counter to WIDTH bits. Adds runtime mode select (Johnson / ring / hold), direction, enable, parallel load, a decoded position index, a wrap pulse and an illegal-state indication. It is used as a sequencer / phase generator in lab-level designs and is driven directly from testbenches.

Parameters:
WIDTH, 5, register width in bits; must be at least 2.
IDX_W, $clog2(2*WIDTH), localparam; width of the index output. Not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
en  input  1  step enable
mode  input  2  00 Johnson, 01 ring, 10 hold, 11 reserved (treated as hold)
dir  input  1  0 = shift left (up), 1 = shift right (down)
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
q  output  WIDTH  counter state
index  output  IDX_W  decoded position of q
wrap  output  1  one-cycle pulse after a step lands on the home state
err  output  1  q is illegal for the current mode

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- Reset (rst = 0): q = 0 and wrap = 0 immediately, with no clock edge needed. Reset wins over everything, including mid-operation.
- Next-state priority, evaluated at each clk rising edge:
  1. load = 1: q <= load_val and wrap <= 0. No legality check. Loading works in any mode.
  2. Otherwise, en = 1 and mode is Johnson or ring: step the counter per the rules below.
  3. Otherwise: q holds and wrap <= 0.
- Johnson step:
  - Up: q <= {q[W-2:0], ~q[W-1]}.
  - Down: q <= {~q[0], q[W-1:1]}.
  - Home state = all zeros. Period = 2*WIDTH.
- Ring step:
  - Up: q <= {q[W-2:0], q[W-1]}.
  - Down: q <= {q[0], q[W-1:1]}.
  - Home state = 1 (bit 0 set). Period = WIDTH.
  - Seed rule (always present): in ring mode with en = 1 and q == 0, the next q is 1 instead of a rotate.
- wrap:
  - Registered. Set to 1 for exactly one cycle when a step (including a seed) writes the home state of the current mode.
  - Cleared otherwise, including by load and by hold.
- index (combinational from q and mode):
  - Johnson: if q[W-1] == 0, index = popcount(q); otherwise index = 2*WIDTH - popcount(q).
  - Ring: index = position of the set bit.
  - Hold or reserved mode: decode as Johnson.
  - If q is illegal, index = 0.
- Legality (combinational):
  - Johnson legal iff the number of adjacent bit changes (q[i] != q[i+1], i = 0..W-2) is at most 1.
  - Ring legal iff popcount(q) == 1.
  - Hold/reserved: use the Johnson rule.
- err: combinational, equal to the illegal flag for the current mode. In ring mode, q == 0 counts as illegal.
- Mode change mid-count: q is preserved, and the next step applies the new mode's rule. If q is illegal under the new mode, err asserts that same cycle.
- Direction change: takes effect on the next step with no bubble.
- dir is ignored while mode is hold.

Optional Feature:
Macro SHIFT_COUNTER_SELF_CORRECT_EN.
- Defined: when en = 1, load = 0, mode is Johnson/ring and q is illegal, the next q is the home state of the current mode and wrap pulses. The ring-zero seed is a special case of this rule. Recovery takes at most 1 cycle.
- Undefined: illegal states are shifted per the normal rules (except the ring seed rule) and can persist indefinitely. err still reports them.

Decomposition:
- Package shift_counter_pkg holds:
  - Mode constants MODE_JOHNSON = 2'b00, MODE_RING = 2'b01, MODE_HOLD = 2'b10.
  - Direction constants DIR_UP = 0, DIR_DOWN = 1.
  - A helper function returning the home state for a given mode and width.
- One sub-module, shift_counter_decode, parameterised by WIDTH: purely combinational, taking q and mode and producing index and the illegal flag. The top module holds the state register, the priority logic and wrap.

Test Plan:
1. Johnson up, WIDTH = 5: rst low for 2 cycles, then mode = 00, dir = 0, en = 1 for 10 cycles.
   -> q = 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, 00000.
   -> index = 1..9 then 0; wrap high exactly in the cycle after q returns to 00000.
2. Ring down from reset: mode = 01, dir = 1, en = 1.
   -> first edge seeds q = 00001 (wrap pulse), then 10000, 01000, 00100, 00010, 00001 (wrap pulse).
   -> err = 1 only while q = 00000 before the first edge.
3. Load and illegal state: load = 1 with load_val = 01010 in Johnson mode.
   -> q = 01010, err = 1, index = 0.
   -> Next step with macro defined: q = 00000 and wrap pulses.
   -> Next step without macro: q = 10101 and err stays 1.
4. Priority and hold:
   -> load and en both high: load wins.
   -> mode = 10 with en = 1 for 3 cycles: q unchanged, wrap = 0.
   -> en = 0 in Johnson mode: q holds.
5. Asynchronous reset mid-count: from q = 01111, assert rst = 0 between clock edges.
   -> q = 00000 and wrap = 0 immediately.
   -> After release, counting resumes from 00001 on the first enabled edge.
6. WIDTH = 8 Johnson, dir toggled mid-sequence after q = 00000111.
   -> Next q = 00000011, and the down sequence continues back to 00000000 with a wrap pulse.
